// File: rtl/cpu_ocimem_access_sequencer.sv
// JTAG debug-monitor memory access sequencer (sysclk domain).
// Turns decoded debug commands into single-word Avalon-MM master transfers
// with an auto-incrementing word address and a waitrequest timeout.
module cpu_ocimem_access_sequencer #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [31:0]       mon_n, wdata_n;
  logic              ready_n, error_n;
  logic              any_pulse;

  // jdo bits outside the address/data fields carry no meaning here.
  logic unused_jdo;
  assign unused_jdo = ^jdo;

  assign any_pulse      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign avm_read       = (state == RD);
  assign avm_write      = (state == WR);
  assign avm_address    = {addr, 2'b00};
  assign avm_byteenable = 4'hF;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      cnt           <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      avm_writedata <= '0;
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      cnt           <= cnt_n;
      MonDReg       <= mon_n;
      monitor_ready <= ready_n;
      monitor_error <= error_n;
      avm_writedata <= wdata_n;
    end
  end

  // Command decode, transfer completion/timeout and overrun detection.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    mon_n   = MonDReg;
    ready_n = monitor_ready;
    error_n = monitor_error;
    wdata_n = avm_writedata;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_n  = jdo[ADDR_W-1:0];
          error_n = 1'b0;
          if (jdo[37]) begin
            state_n = RD;
            ready_n = 1'b0;
            cnt_n   = '0;
          end else begin
            ready_n = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_n = jdo[34:3];
          state_n = WR;
          ready_n = 1'b0;
          cnt_n   = '0;
        end else if (take_no_action_ocimem_a) begin
          state_n = RD;
          ready_n = 1'b0;
          cnt_n   = '0;
        end
      end
      RD, WR: begin
        if (any_pulse) error_n = 1'b1;
        if (!avm_waitrequest) begin
          if (state == RD) mon_n = avm_readdata;
          addr_n  = addr + 1'b1;
          ready_n = 1'b1;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          error_n = 1'b1;
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ocimem_access_sequencer.sv
// Scoreboard bench for cpu_ocimem_access_sequencer with a stallable slave model.
module tb_cpu_ocimem_access_sequencer;

  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0]       jdo;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       data;
  } xfer_t;

  xfer_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    stall_cfg = 0;
  int    stall_cnt = 0;
  bit    stuck = 1'b0;
  int    wr_cycles = 0;
  int    rd_cycles = 0;
  logic [31:0] exp_mon;

  cpu_ocimem_access_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave: stalls stall_cfg cycles per transfer, or forever while stuck.
  assign avm_waitrequest = stuck || (stall_cnt < stall_cfg);

  always @(posedge clk) begin
    if ((avm_read || avm_write) && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else                                            stall_cnt <= 0;
  end

  // Monitor: pops the scoreboard on each completed bus transfer.
  always @(negedge clk) begin
    if (!reset && (avm_read || avm_write)) begin
      chk("rw_exclusive", 64'(avm_read & avm_write), 64'd0);
      chk("byteenable", 64'(avm_byteenable), 64'hF);
      if (avm_write) wr_cycles++;
      if (avm_read)  rd_cycles++;
      if (!avm_waitrequest) begin
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          xfer_t e;
          e = sb_q.pop_front();
          chk("xfer_kind", 64'(avm_write), 64'(e.wr));
          chk("xfer_addr", 64'(avm_address), 64'(e.addr));
          if (e.wr) chk("xfer_wdata", 64'(avm_writedata), 64'(e.data));
        end
      end
    end
  end

  function automatic logic [37:0] jdo_a(input logic rd, input logic [ADDR_W-1:0] a);
    logic [37:0] j;
    j = '0;
    j[37] = rd;
    j[ADDR_W-1:0] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Called at a negedge; holds the pulse across exactly one rising edge.
  task automatic pulse(input int which, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (which == 0);
    take_action_ocimem_b    = (which == 1);
    take_no_action_ocimem_a = (which == 2);
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (monitor_ready) break;
      @(negedge clk);
    end
    chk(tag, 64'(monitor_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    reset = 1'b1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    avm_readdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mon", 64'(MonDReg), 64'd0);
    chk("rst_ready", 64'(monitor_ready), 64'd0);
    chk("rst_error", 64'(monitor_error), 64'd0);
    chk("rst_rw", 64'({avm_read, avm_write}), 64'd0);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_wdata", 64'(avm_writedata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: load address 0x010 with read, zero-wait slave.
    avm_readdata = 32'hCAFEF00D; stall_cfg = 0; exp_mon = 32'hCAFEF00D;
    sb_q.push_back('{wr: 1'b0, addr: 11'h040, data: 32'h0});
    pulse(0, jdo_a(1'b1, 9'h010));
    chk("t1_ready_low", 64'(monitor_ready), 64'd0);
    wait_ready("t1_ready");
    chk("t1_mon", 64'(MonDReg), 64'(exp_mon));
    chk("t1_addr", 64'(avm_address), 64'h044);
    chk("t1_error", 64'(monitor_error), 64'd0);

    // 2: write with 3 stall cycles, then read-back of next word.
    stall_cfg = 3; wr_cycles = 0;
    sb_q.push_back('{wr: 1'b1, addr: 11'h044, data: 32'h12345678});
    pulse(1, jdo_b(32'h12345678));
    wait_ready("t2_ready");
    chk("t2_wr_cycles", 64'(wr_cycles), 64'd4);
    chk("t2_mon_keep", 64'(MonDReg), 64'(exp_mon));
    chk("t2_addr", 64'(avm_address), 64'h048);
    stall_cfg = 0; avm_readdata = 32'h0BADBEEF; exp_mon = 32'h0BADBEEF;
    sb_q.push_back('{wr: 1'b0, addr: 11'h048, data: 32'h0});
    pulse(2, '0);
    wait_ready("t2_rd_ready");
    chk("t2_mon", 64'(MonDReg), 64'(exp_mon));

    // 3: wrap-around from the top word.
    pulse(0, jdo_a(1'b0, 9'h1FF));
    wait_ready("t3_load_ready");
    chk("t3_addr_top", 64'(avm_address), 64'h7FC);
    avm_readdata = 32'h11112222;
    sb_q.push_back('{wr: 1'b0, addr: 11'h7FC, data: 32'h0});
    pulse(2, '0);
    wait_ready("t3_rd1");
    avm_readdata = 32'h33334444; exp_mon = 32'h33334444;
    sb_q.push_back('{wr: 1'b0, addr: 11'h000, data: 32'h0});
    pulse(2, '0);
    wait_ready("t3_rd2");
    chk("t3_mon", 64'(MonDReg), 64'(exp_mon));
    chk("t3_addr_next", 64'(avm_address), 64'h004);

    // 4: timeout with waitrequest stuck high.
    stuck = 1'b1; rd_cycles = 0; avm_readdata = 32'hDEADDEAD;
    pulse(2, '0);
    wait_ready("t4_ready");
    chk("t4_rd_cycles", 64'(rd_cycles), 64'd4);
    chk("t4_read_low", 64'(avm_read), 64'd0);
    chk("t4_error", 64'(monitor_error), 64'd1);
    chk("t4_mon_keep", 64'(MonDReg), 64'(exp_mon));
    chk("t4_addr_keep", 64'(avm_address), 64'h004);
    stuck = 1'b0;
    pulse(0, jdo_a(1'b0, 9'h020));
    chk("t4_error_clr", 64'(monitor_error), 64'd0);

    // 5: overrun write pulse during a stalled read.
    stall_cfg = 2; avm_readdata = 32'h5A5A1234; exp_mon = 32'h5A5A1234;
    wr_before = wr_cycles;
    sb_q.push_back('{wr: 1'b0, addr: 11'h080, data: 32'h0});
    pulse(2, '0);
    pulse(1, jdo_b(32'hFFFFFFFF));
    wait_ready("t5_ready");
    chk("t5_mon", 64'(MonDReg), 64'(exp_mon));
    chk("t5_error", 64'(monitor_error), 64'd1);
    chk("t5_no_write", 64'(wr_cycles), 64'(wr_before));
    chk("t5_addr", 64'(avm_address), 64'h084);
    repeat (3) @(negedge clk);
    chk("t5_idle_write", 64'(avm_write), 64'd0);

    // 6: reset while a write is stalled.
    stuck = 1'b1;
    pulse(1, jdo_b(32'hA5A5A5A5));
    chk("t6_write_active", 64'(avm_write), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_write", 64'(avm_write), 64'd0);
    chk("t6_addr", 64'(avm_address), 64'd0);
    chk("t6_ready", 64'(monitor_ready), 64'd0);
    chk("t6_error", 64'(monitor_error), 64'd0);
    chk("t6_mon", 64'(MonDReg), 64'd0);
    reset = 1'b0; stuck = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
